// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: product layout, default sizing and
// the accumulation-stage state encoding.
package mac_pkg;

    // Packed product layout: [15:8] real, [7:0] imaginary, both signed.
    localparam int unsigned PROD_W = 16;
    localparam int unsigned PART_W = 8;

    // Default sizing used by the top-level MAC.
    localparam int unsigned DEF_N_TERMS = 4;
    localparam int unsigned DEF_ACC_W   = 10;

    // Accumulating products, or holding a finished result for the consumer.
    typedef enum logic [0:0] {
        StAccum = 1'b0,
        StHold  = 1'b1
    } state_e;

    // Term counter width; a single-term configuration still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n_terms);
        return (n_terms <= 1) ? 1 : $clog2(n_terms);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: ACC_W-bit accumulator plus a PART_W-bit signed
// operand, clamped to the accumulator's two's complement range.
module sat_add
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PART_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    // One guard bit makes the true sum of two ACC_W-range values representable.
    logic [ACC_W:0] a_ext;
    logic [ACC_W:0] b_ext;
    logic [ACC_W:0] full;

    // Extend, add, and clamp when the guard bit disagrees with the sign bit.
    always_comb begin
        a_ext = {a[ACC_W-1], a};
        b_ext = {{(ACC_W + 1 - PART_W){b[PART_W-1]}}, b};
        full  = a_ext + b_ext;
        sat   = full[ACC_W] ^ full[ACC_W-1];
        if (!sat) begin
            sum = full[ACC_W-1:0];
        end else if (full[ACC_W]) begin
            // Negative overflow: clamp to the most negative value.
            sum = {1'b1, {(ACC_W - 1){1'b0}}};
        end else begin
            // Positive overflow: clamp to the most positive value.
            sum = {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end

endmodule

// File: rtl/complex_mac_acc.sv
// Complex accumulation stage: sums N_TERMS signed complex products into
// saturating real/imaginary accumulators and holds each finished sum on a
// valid/ready output until the consumer takes it.
module complex_mac_acc
    import mac_pkg::*;
#(
    parameter int unsigned N_TERMS = DEF_N_TERMS,
    parameter int unsigned ACC_W   = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_re,
    output logic [ACC_W-1:0]  acc_im,
    output logic              overflow
);

    localparam int unsigned     CNT_W    = cnt_width(N_TERMS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    state_e state_q, state_d;

    logic [ACC_W-1:0] re_q, re_d;
    logic [ACC_W-1:0] im_q, im_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] sum_re, sum_im;
    logic             sat_re, sat_im;
    logic             accept;
    logic             release_res;
    logic             last_term;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_add_re (
        .a   (re_q),
        .b   (prod[PROD_W-1:PART_W]),
        .sum (sum_re),
        .sat (sat_re)
    );

    sat_add #(
        .ACC_W (ACC_W)
    ) u_add_im (
        .a   (im_q),
        .b   (prod[PART_W-1:0]),
        .sum (sum_im),
        .sat (sat_im)
    );

    // Handshake qualifiers; clr priority is applied in the next-state logic.
    always_comb begin
        accept      = prod_valid && (state_q == StAccum);
        release_res = acc_ready && (state_q == StHold);
        last_term   = (cnt_q == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the final accepted term enters HOLD, the consumer releases it.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = StAccum;
        end else begin
            unique case (state_q)
                StAccum: if (accept && last_term) state_d = StHold;
                StHold:  if (acc_ready)           state_d = StAccum;
                default: state_d = StAccum;
            endcase
        end
    end

    // Handshake outputs decoded purely from registered state.
    always_comb begin
        prod_ready = (state_q == StAccum);
        acc_valid  = (state_q == StHold);
    end

    // Accumulator, counter and sticky overflow next-state.
    always_comb begin
        re_d  = re_q;
        im_d  = im_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr || release_res) begin
            // Abort or hand-off: start the next result from zero.
            re_d  = '0;
            im_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            re_d  = sum_re;
            im_d  = sum_im;
            ovf_d = ovf_q | sat_re | sat_im;
            cnt_d = last_term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers; partial sums are discarded on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            re_q  <= '0;
            im_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            re_q  <= re_d;
            im_q  <= im_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Result outputs come straight from the registers, so they are stable in HOLD.
    always_comb begin
        acc_re   = re_q;
        acc_im   = im_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_complex_mac_acc.sv
// Bench for complex_mac_acc: three instances (N_TERMS = 4, 8, 1) checked every
// cycle against an integer reference model, plus directed literal checks.
module tb_complex_mac_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr   [3];
    logic       pv    [3];
    logic       ar    [3];
    logic [15:0] prod [3];
    logic       prd   [3];
    logic       av    [3];
    logic       ovf   [3];
    logic [9:0] are   [3];
    logic [9:0] aim   [3];

    int checks = 0;
    int fails  = 0;

    // Reference model state.
    int nterms [3] = '{4, 8, 1};
    int m_re   [3];
    int m_im   [3];
    int m_cnt  [3];
    bit m_hold [3];
    bit m_ovf  [3];

    always #5 clk = ~clk;

    complex_mac_acc #(.N_TERMS(4), .ACC_W(10)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr[0]), .prod_valid(pv[0]), .prod_ready(prd[0]),
        .prod(prod[0]), .acc_valid(av[0]), .acc_ready(ar[0]), .acc_re(are[0]),
        .acc_im(aim[0]), .overflow(ovf[0])
    );

    complex_mac_acc #(.N_TERMS(8), .ACC_W(10)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr[1]), .prod_valid(pv[1]), .prod_ready(prd[1]),
        .prod(prod[1]), .acc_valid(av[1]), .acc_ready(ar[1]), .acc_re(are[1]),
        .acc_im(aim[1]), .overflow(ovf[1])
    );

    complex_mac_acc #(.N_TERMS(1), .ACC_W(10)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr[2]), .prod_valid(pv[2]), .prod_ready(prd[2]),
        .prod(prod[2]), .acc_valid(av[2]), .acc_ready(ar[2]), .acc_re(are[2]),
        .acc_im(aim[2]), .overflow(ovf[2])
    );

    task automatic check(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", name, k, $time, act, exp);
        end
    endtask

    function automatic int clamp10(input int v, inout bit s);
        if (v > 511) begin
            s = 1'b1;
            return 511;
        end
        if (v < -512) begin
            s = 1'b1;
            return -512;
        end
        return v;
    endfunction

    // Reference model: result-level behaviour with plain integers.
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst || clr[k] || (m_hold[k] && ar[k])) begin
                m_re[k]   = 0;
                m_im[k]   = 0;
                m_cnt[k]  = 0;
                m_hold[k] = 1'b0;
                m_ovf[k]  = 1'b0;
            end else if (!m_hold[k] && pv[k]) begin
                m_re[k] = clamp10(m_re[k] + int'($signed(prod[k][15:8])), m_ovf[k]);
                m_im[k] = clamp10(m_im[k] + int'($signed(prod[k][7:0])), m_ovf[k]);
                m_cnt[k]++;
                if (m_cnt[k] == nterms[k]) begin
                    m_hold[k] = 1'b1;
                    m_cnt[k]  = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                check("prod_ready", k, int'(prd[k]), int'(!m_hold[k]));
                check("acc_valid", k, int'(av[k]), int'(m_hold[k]));
                check("acc_re", k, int'($signed(are[k])), m_re[k]);
                check("acc_im", k, int'($signed(aim[k])), m_im[k]);
                check("overflow", k, int'(ovf[k]), int'(m_ovf[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Offer one product and wait (bounded) for acceptance; returns stall cycles.
    task automatic send(input int k, input int re, input int im, output int waited);
        bit done = 1'b0;
        pv[k]   = 1'b1;
        prod[k] = {8'(re), 8'(im)};
        waited  = 0;
        while (!done && waited < 50) begin
            if (prd[k]) begin
                tick();
                done = 1'b1;
            end else begin
                tick();
                waited++;
            end
        end
        pv[k] = 1'b0;
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL send_timeout[dut%0d]: got no acceptance, expected one within 50", k);
        end
    endtask

    task automatic release_result(input int k);
        ar[k] = 1'b1;
        tick();
        ar[k] = 1'b0;
    endtask

    int w;

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b0; pv[k] = 1'b0; ar[k] = 1'b0; prod[k] = '0;
        end
        #13;
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", k, int'(av[k]), 0);
            check("rst_ready", k, int'(prd[k]), 1);
            check("rst_re", k, int'($signed(are[k])), 0);
        end
        rst = 1'b1;
        tick();

        // Basic sum.
        send(0, 3, -2, w); send(0, 5, 1, w); send(0, -4, 7, w); send(0, 2, 2, w);
        check("basic_valid", 0, int'(av[0]), 1);
        check("basic_re", 0, int'($signed(are[0])), 6);
        check("basic_im", 0, int'($signed(aim[0])), 8);
        check("basic_ovf", 0, int'(ovf[0]), 0);

        // Back-pressure with a pending product.
        pv[0]   = 1'b1;
        prod[0] = {8'(1), 8'(2)};
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 0, int'(prd[0]), 0);
            check("bp_re", 0, int'($signed(are[0])), 6);
            check("bp_im", 0, int'($signed(aim[0])), 8);
            tick();
        end
        release_result(0);
        check("rel_re", 0, int'($signed(are[0])), 0);
        check("rel_ready", 0, int'(prd[0]), 1);
        tick();
        pv[0] = 1'b0;
        check("pend_re", 0, int'($signed(are[0])), 1);
        check("pend_im", 0, int'($signed(aim[0])), 2);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;

        // Saturation.
        for (int i = 0; i < 8; i++) send(1, 127, -128, w);
        check("sat_re", 1, int'($signed(are[1])), 511);
        check("sat_im", 1, int'($signed(aim[1])), -512);
        check("sat_ovf", 1, int'(ovf[1]), 1);
        release_result(1);
        for (int i = 0; i < 8; i++) send(1, 1, -1, w);
        check("nosat_re", 1, int'($signed(are[1])), 8);
        check("nosat_im", 1, int'($signed(aim[1])), -8);
        check("nosat_ovf", 1, int'(ovf[1]), 0);
        release_result(1);

        // Mid-run clear drops the concurrent product.
        send(0, 10, 10, w); send(0, 10, 10, w);
        check("pre_clr_re", 0, int'($signed(are[0])), 20);
        pv[0]   = 1'b1;
        prod[0] = {8'(1), 8'(1)};
        clr[0]  = 1'b1;
        tick();
        clr[0] = 1'b0;
        pv[0]  = 1'b0;
        check("clr_re", 0, int'($signed(are[0])), 0);
        check("clr_im", 0, int'($signed(aim[0])), 0);
        for (int i = 0; i < 4; i++) send(0, 1, 0, w);
        check("clr_sum_valid", 0, int'(av[0]), 1);
        check("clr_sum_re", 0, int'($signed(are[0])), 4);
        check("clr_sum_im", 0, int'($signed(aim[0])), 0);

        // Asynchronous reset while holding a result, between clock edges.
        #1;
        rst = 1'b0;
        #1;
        check("arst_valid", 0, int'(av[0]), 0);
        check("arst_ready", 0, int'(prd[0]), 1);
        check("arst_re", 0, int'($signed(are[0])), 0);
        check("arst_im", 0, int'($signed(aim[0])), 0);
        rst = 1'b1;
        tick();

        // Single-term results with the consumer always ready.
        ar[2] = 1'b1;
        send(2, -7, 3, w);
        check("n1_valid_a", 2, int'(av[2]), 1);
        check("n1_re_a", 2, int'($signed(are[2])), -7);
        check("n1_im_a", 2, int'($signed(aim[2])), 3);
        send(2, 4, 4, w);
        check("n1_stall", 2, w, 1);
        check("n1_re_b", 2, int'($signed(are[2])), 4);
        check("n1_im_b", 2, int'($signed(aim[2])), 4);
        tick();
        ar[2] = 1'b0;

        // Randomized traffic on all instances, checked against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                pv[k]   = ($urandom_range(0, 3) != 0);
                prod[k] = 16'($urandom);
                if (k == 1 && $urandom_range(0, 1) == 1) begin
                    prod[k] = {8'($urandom_range(100, 127)), 8'($urandom_range(128, 160))};
                end
                ar[k]  = ($urandom_range(0, 2) == 0);
                clr[k] = ($urandom_range(0, 49) == 0);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0; ar[k] = 1'b0; clr[k] = 1'b0;
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
